// File: rtl/cp0_regfile_pkg.sv
// Shared definitions for the CP0 register file: WB->CP0 bus layout,
// CP0 register addresses and exception codes.
package cp0_regfile_pkg;

  localparam int unsigned WB_TO_CP0_REGISTER_BUS_WD = 110;

  // Bit offsets of each field within the flat bus vector
  localparam int unsigned BUS_EX_OFS       = 109;
  localparam int unsigned BUS_EXCODE_OFS   = 104;
  localparam int unsigned BUS_BADVADDR_OFS = 72;
  localparam int unsigned BUS_BD_OFS       = 71;
  localparam int unsigned BUS_PC_OFS       = 39;
  localparam int unsigned BUS_MTC0_WE_OFS  = 38;
  localparam int unsigned BUS_ADDR_OFS     = 33;
  localparam int unsigned BUS_WDATA_OFS    = 1;
  localparam int unsigned BUS_ERET_OFS     = 0;

  localparam int unsigned CP0_ADDR_W = 5;
  localparam int unsigned EXCODE_W   = 5;
  localparam int unsigned DATA_W     = 32;

  localparam logic [CP0_ADDR_W-1:0] CR_BADVADDR = 5'd8;
  localparam logic [CP0_ADDR_W-1:0] CR_COUNT    = 5'd9;
  localparam logic [CP0_ADDR_W-1:0] CR_COMPARE  = 5'd11;
  localparam logic [CP0_ADDR_W-1:0] CR_STATUS   = 5'd12;
  localparam logic [CP0_ADDR_W-1:0] CR_CAUSE    = 5'd13;
  localparam logic [CP0_ADDR_W-1:0] CR_EPC      = 5'd14;

  localparam logic [EXCODE_W-1:0] EX_INT  = 5'h00;
  localparam logic [EXCODE_W-1:0] EX_ADEL = 5'h04;
  localparam logic [EXCODE_W-1:0] EX_ADES = 5'h05;
  localparam logic [EXCODE_W-1:0] EX_SYS  = 5'h08;
  localparam logic [EXCODE_W-1:0] EX_BP   = 5'h09;
  localparam logic [EXCODE_W-1:0] EX_RI   = 5'h0A;
  localparam logic [EXCODE_W-1:0] EX_OV   = 5'h0C;

  localparam logic [DATA_W-1:0] STATUS_RESET = 32'h0040_0000;

  // Field order mirrors the flat bus, MSB first
  typedef struct packed {
    logic                  ex;
    logic [EXCODE_W-1:0]   excode;
    logic [DATA_W-1:0]     badvaddr;
    logic                  bd;
    logic [DATA_W-1:0]     pc;
    logic                  mtc0_we;
    logic [CP0_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     wdata;
    logic                  eret;
  } wb_cp0_bus_t;

  function automatic logic is_addr_exc(input logic [EXCODE_W-1:0] code);
    return (code == EX_ADEL) || (code == EX_ADES);
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer: divided Count increment, Compare register and
// the sticky timer-interrupt flag.
module cp0_timer
  import cp0_regfile_pkg::*;
#(
  parameter int unsigned COUNT_DIV = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              count_we,
  input  logic              compare_we,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] count,
  output logic [DATA_W-1:0] compare,
  output logic              ti
);

  localparam bit DIV_ONE = (COUNT_DIV == 1);

  logic tick;
  logic inc_c;

  // With a divide of 1 the phase bit stays at 0 and every clock increments
  assign inc_c = DIV_ONE | tick;

  always_ff @(posedge clk) begin
    if (reset) begin
      tick <= 1'b0;
    end else if (count_we || DIV_ONE) begin
      tick <= 1'b0;
    end else begin
      tick <= ~tick;
    end
  end

  // A software write beats the increment of the same cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (count_we) begin
      count <= wdata;
    end else if (inc_c) begin
      count <= count + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      compare <= '0;
    end else if (compare_we) begin
      compare <= wdata;
    end
  end

  // Compare write clears TI even when a match would set it this cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      ti <= 1'b0;
    end else if (compare_we) begin
      ti <= 1'b0;
    end else if (count == compare) begin
      ti <= 1'b1;
    end
  end

endmodule

// File: rtl/cp0_regfile.sv
// CP0 system-control register file fed by the write-back stage: Status,
// Cause, EPC, BadVAddr plus the timer, with mfc0 read mux and interrupt request.
module cp0_regfile
  import cp0_regfile_pkg::*;
#(
  parameter logic [31:0] EX_ENTRY  = 32'hBFC0_0380,
  parameter int unsigned COUNT_DIV = 2
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [WB_TO_CP0_REGISTER_BUS_WD-1:0] wb_to_cp0_register_bus,
  input  logic [5:0]                           ext_int_in,
  output logic [DATA_W-1:0]                    cp0_rdata,
  output logic [DATA_W-1:0]                    cp0_epc,
  output logic [DATA_W-1:0]                    cp0_ex_entry,
  output logic                                 cp0_status_exl,
  output logic                                 int_req
);

  wb_cp0_bus_t bus;
  assign bus = wb_cp0_bus_t'(wb_to_cp0_register_bus);

  logic [7:0]          status_im;
  logic                status_exl;
  logic                status_ie;
  logic                cause_bd;
  logic [5:0]          cause_ip_hw;
  logic [1:0]          cause_ip_sw;
  logic [EXCODE_W-1:0] cause_exccode;
  logic [DATA_W-1:0]   epc;
  logic [DATA_W-1:0]   badvaddr;

  logic [DATA_W-1:0]   count;
  logic [DATA_W-1:0]   compare;
  logic                ti;

  logic                mtc0_c;
  logic [DATA_W-1:0]   status_c;
  logic [DATA_W-1:0]   cause_c;

  // mtc0 only lands when neither an exception nor an eret owns the cycle
  assign mtc0_c = bus.mtc0_we & ~bus.ex & ~bus.eret;

  cp0_timer #(
    .COUNT_DIV (COUNT_DIV)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .count_we   (mtc0_c && (bus.addr == CR_COUNT)),
    .compare_we (mtc0_c && (bus.addr == CR_COMPARE)),
    .wdata      (bus.wdata),
    .count      (count),
    .compare    (compare),
    .ti         (ti)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      status_im     <= '0;
      status_exl    <= 1'b0;
      status_ie     <= 1'b0;
      cause_bd      <= 1'b0;
      cause_ip_hw   <= '0;
      cause_ip_sw   <= '0;
      cause_exccode <= '0;
      epc           <= '0;
      badvaddr      <= '0;
    end else begin
      cause_ip_hw <= {ext_int_in[5] | ti, ext_int_in[4:0]};
      if (bus.ex) begin
        cause_exccode <= bus.excode;
        // Nested exceptions keep the original EPC and BD
        if (!status_exl) begin
          epc        <= bus.bd ? bus.pc - 32'd4 : bus.pc;
          cause_bd   <= bus.bd;
          status_exl <= 1'b1;
        end
        if (is_addr_exc(bus.excode)) begin
          badvaddr <= bus.badvaddr;
        end
      end else if (bus.eret) begin
        status_exl <= 1'b0;
      end else if (bus.mtc0_we) begin
        case (bus.addr)
          CR_STATUS: begin
            status_im  <= bus.wdata[15:8];
            status_exl <= bus.wdata[1];
            status_ie  <= bus.wdata[0];
          end
          CR_CAUSE: cause_ip_sw <= bus.wdata[9:8];
          CR_EPC:   epc         <= bus.wdata;
          default:  ;
        endcase
      end
    end
  end

  assign status_c = {9'b0, 1'b1, 6'b0, status_im, 6'b0, status_exl, status_ie};
  assign cause_c  = {cause_bd, ti, 14'b0, cause_ip_hw, cause_ip_sw, 1'b0,
                     cause_exccode, 2'b0};

  // mfc0 read: shows pre-write state in the cycle of a write
  always_comb begin
    cp0_rdata = '0;
    case (bus.addr)
      CR_BADVADDR: cp0_rdata = badvaddr;
      CR_COUNT:    cp0_rdata = count;
      CR_COMPARE:  cp0_rdata = compare;
      CR_STATUS:   cp0_rdata = status_c;
      CR_CAUSE:    cp0_rdata = cause_c;
      CR_EPC:      cp0_rdata = epc;
      default:     cp0_rdata = '0;
    endcase
  end

  assign cp0_epc        = epc;
  assign cp0_ex_entry   = EX_ENTRY;
  assign cp0_status_exl = status_exl;
  assign int_req        = status_ie & ~status_exl & (|(cause_c[15:8] & status_im));

endmodule

// File: tb/tb_cp0_regfile.sv
// Directed self-checking bench for cp0_regfile (COUNT_DIV=2).
module tb_cp0_regfile;
  import cp0_regfile_pkg::*;

  logic        clk;
  logic        reset;
  wb_cp0_bus_t bus;
  logic [WB_TO_CP0_REGISTER_BUS_WD-1:0] bus_bits;
  logic [5:0]  ext_int_in;
  logic [31:0] cp0_rdata;
  logic [31:0] cp0_epc;
  logic [31:0] cp0_ex_entry;
  logic        cp0_status_exl;
  logic        int_req;

  int checks;
  int failures;

  assign bus_bits = bus;

  cp0_regfile #(
    .EX_ENTRY  (32'hBFC0_0380),
    .COUNT_DIV (2)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .wb_to_cp0_register_bus (bus_bits),
    .ext_int_in             (ext_int_in),
    .cp0_rdata              (cp0_rdata),
    .cp0_epc                (cp0_epc),
    .cp0_ex_entry           (cp0_ex_entry),
    .cp0_status_exl         (cp0_status_exl),
    .int_req                (int_req)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    bus.mtc0_we = 1'b0;
    bus.addr    = a;
    #1;
    d = cp0_rdata;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] v);
    bus         = '0;
    bus.mtc0_we = 1'b1;
    bus.addr    = a;
    bus.wdata   = v;
    step();
    bus.mtc0_we = 1'b0;
  endtask

  task automatic raise_ex(input logic [4:0] code, input logic bdv,
                          input logic [31:0] pcv, input logic [31:0] bva);
    bus          = '0;
    bus.ex       = 1'b1;
    bus.excode   = code;
    bus.bd       = bdv;
    bus.pc       = pcv;
    bus.badvaddr = bva;
    step();
    bus = '0;
  endtask

  task automatic do_eret();
    bus      = '0;
    bus.eret = 1'b1;
    step();
    bus = '0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    bus = '0;
    ext_int_in = '0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    rd(CR_STATUS, d);
    checks++; if (d !== 32'h0040_0000) begin failures++; $display("FAIL reset_status got=%h exp=%h", d, 32'h0040_0000); end
    checks++; if (int_req !== 1'b0) begin failures++; $display("FAIL reset_int_req got=%b exp=0", int_req); end
    checks++; if (cp0_epc !== 32'h0) begin failures++; $display("FAIL reset_epc got=%h exp=0", cp0_epc); end
    checks++; if (cp0_status_exl !== 1'b0) begin failures++; $display("FAIL reset_exl got=%b exp=0", cp0_status_exl); end
    checks++; if (cp0_ex_entry !== 32'hBFC0_0380) begin failures++; $display("FAIL ex_entry got=%h exp=bfc00380", cp0_ex_entry); end
    rd(CR_CAUSE, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL reset_cause got=%h exp=0", d); end
    rd(CR_COUNT, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL reset_count got=%h exp=0", d); end
  endtask

  task automatic test_exception();
    logic [31:0] d;
    // Park Compare far away so TI stays clear through these checks
    mtc0(CR_COMPARE, 32'hFFFF_0000);
    step();
    step();
    raise_ex(EX_ADEL, 1'b1, 32'hBFC0_0100, 32'h1);
    checks++; if (cp0_epc !== 32'hBFC0_00FC) begin failures++; $display("FAIL ex_epc got=%h exp=bfc000fc", cp0_epc); end
    checks++; if (cp0_status_exl !== 1'b1) begin failures++; $display("FAIL ex_exl got=%b exp=1", cp0_status_exl); end
    rd(CR_CAUSE, d);
    checks++; if (d !== 32'h8000_0010) begin failures++; $display("FAIL ex_cause got=%h exp=80000010", d); end
    rd(CR_BADVADDR, d);
    checks++; if (d !== 32'h1) begin failures++; $display("FAIL ex_badvaddr got=%h exp=1", d); end
    raise_ex(EX_SYS, 1'b0, 32'h0000_0200, 32'hDEAD_BEEF);
    checks++; if (cp0_epc !== 32'hBFC0_00FC) begin failures++; $display("FAIL nested_epc got=%h exp=bfc000fc", cp0_epc); end
    rd(CR_CAUSE, d);
    checks++; if (d !== 32'h8000_0020) begin failures++; $display("FAIL nested_cause got=%h exp=80000020", d); end
    rd(CR_BADVADDR, d);
    checks++; if (d !== 32'h1) begin failures++; $display("FAIL nested_badvaddr got=%h exp=1", d); end
  endtask

  task automatic test_eret_priority();
    logic [31:0] d;
    do_eret();
    checks++; if (cp0_status_exl !== 1'b0) begin failures++; $display("FAIL eret_exl got=%b exp=0", cp0_status_exl); end
    checks++; if (cp0_epc !== 32'hBFC0_00FC) begin failures++; $display("FAIL eret_epc got=%h exp=bfc000fc", cp0_epc); end
    // ex and mtc0 Status in one cycle: the write must be dropped
    bus         = '0;
    bus.ex      = 1'b1;
    bus.excode  = EX_OV;
    bus.pc      = 32'h0000_0300;
    bus.mtc0_we = 1'b1;
    bus.addr    = CR_STATUS;
    bus.wdata   = 32'h0000_FF03;
    step();
    bus = '0;
    rd(CR_STATUS, d);
    checks++; if (d !== 32'h0040_0002) begin failures++; $display("FAIL ex_over_mtc0_status got=%h exp=00400002", d); end
    checks++; if (cp0_epc !== 32'h0000_0300) begin failures++; $display("FAIL ex_over_mtc0_epc got=%h exp=00000300", cp0_epc); end
    rd(CR_CAUSE, d);
    checks++; if (d !== 32'h0000_0030) begin failures++; $display("FAIL ex_over_mtc0_cause got=%h exp=00000030", d); end
    do_eret();
    // EPC write: old value visible until the edge
    bus         = '0;
    bus.mtc0_we = 1'b1;
    bus.addr    = CR_EPC;
    bus.wdata   = 32'h0000_1234;
    #1;
    checks++; if (cp0_rdata !== 32'h0000_0300) begin failures++; $display("FAIL no_bypass got=%h exp=00000300", cp0_rdata); end
    step();
    bus.mtc0_we = 1'b0;
    #1;
    checks++; if (cp0_rdata !== 32'h0000_1234) begin failures++; $display("FAIL mtc0_epc got=%h exp=00001234", cp0_rdata); end
    mtc0(5'd10, 32'h5555_AAAA);
    rd(5'd10, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL unmapped_read got=%h exp=0", d); end
  endtask

  task automatic test_timer();
    logic [31:0] d;
    int n;
    bit found;
    mtc0(CR_COUNT, 32'h0);
    mtc0(CR_COMPARE, 32'd10);
    mtc0(CR_STATUS, 32'h0000_8001);
    rd(CR_STATUS, d);
    checks++; if (d !== 32'h0040_8001) begin failures++; $display("FAIL timer_status got=%h exp=00408001", d); end
    // Count=0 at edge W; Count hits 10 at W+20, TI at W+21, IP7 at W+22
    n = 2;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      n++;
      if (int_req === 1'b1) found = 1'b1;
    end
    checks++; if (!found) begin failures++; $display("FAIL timer_timeout got=no_int_req exp=int_req"); end
    checks++; if (n !== 22) begin failures++; $display("FAIL timer_latency got=%0d exp=22", n); end
    rd(CR_CAUSE, d);
    checks++; if (d !== 32'h4000_8030) begin failures++; $display("FAIL timer_cause got=%h exp=40008030", d); end
    mtc0(CR_COMPARE, 32'd50);
    rd(CR_CAUSE, d);
    checks++; if (d[30] !== 1'b0) begin failures++; $display("FAIL ti_clear got=%b exp=0", d[30]); end
    rd(CR_COMPARE, d);
    checks++; if (d !== 32'd50) begin failures++; $display("FAIL compare_rd got=%h exp=00000032", d); end
    step();
    checks++; if (int_req !== 1'b0) begin failures++; $display("FAIL timer_int_clear got=%b exp=0", int_req); end
  endtask

  task automatic test_sw_hw_int();
    logic [31:0] d;
    mtc0(CR_STATUS, 32'h0000_0101);
    checks++; if (int_req !== 1'b0) begin failures++; $display("FAIL sw_int_idle got=%b exp=0", int_req); end
    mtc0(CR_CAUSE, 32'h8000_0100);
    checks++; if (int_req !== 1'b1) begin failures++; $display("FAIL sw_int_raise got=%b exp=1", int_req); end
    rd(CR_CAUSE, d);
    checks++; if ((d & 32'h8000_0300) !== 32'h0000_0100) begin failures++; $display("FAIL cause_write_mask got=%h exp=00000100", d & 32'h8000_0300); end
    raise_ex(EX_INT, 1'b0, 32'h0000_0400, 32'h0);
    checks++; if (int_req !== 1'b0) begin failures++; $display("FAIL int_masked_exl got=%b exp=0", int_req); end
    checks++; if (cp0_epc !== 32'h0000_0400) begin failures++; $display("FAIL int_epc got=%h exp=00000400", cp0_epc); end
    rd(CR_BADVADDR, d);
    checks++; if (d !== 32'h1) begin failures++; $display("FAIL int_badvaddr_kept got=%h exp=1", d); end
    do_eret();
    checks++; if (int_req !== 1'b1) begin failures++; $display("FAIL int_after_eret got=%b exp=1", int_req); end
    mtc0(CR_CAUSE, 32'h0);
    checks++; if (int_req !== 1'b0) begin failures++; $display("FAIL sw_int_clear got=%b exp=0", int_req); end
    mtc0(CR_STATUS, 32'h0000_0401);
    ext_int_in = 6'b000001;
    #1;
    checks++; if (int_req !== 1'b0) begin failures++; $display("FAIL hw_int_presample got=%b exp=0", int_req); end
    step();
    checks++; if (int_req !== 1'b1) begin failures++; $display("FAIL hw_int_raise got=%b exp=1", int_req); end
    ext_int_in = '0;
    step();
    checks++; if (int_req !== 1'b0) begin failures++; $display("FAIL hw_int_drop got=%b exp=0", int_req); end
  endtask

  task automatic test_count_wrap_reset();
    logic [31:0] d;
    mtc0(CR_COUNT, 32'hFFFF_FFFF);
    rd(CR_COUNT, d);
    checks++; if (d !== 32'hFFFF_FFFF) begin failures++; $display("FAIL count_write got=%h exp=ffffffff", d); end
    step();
    rd(CR_COUNT, d);
    checks++; if (d !== 32'hFFFF_FFFF) begin failures++; $display("FAIL count_hold got=%h exp=ffffffff", d); end
    step();
    rd(CR_COUNT, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL count_wrap got=%h exp=0", d); end
    step();
    step();
    step();
    reset       = 1'b1;
    bus         = '0;
    bus.ex      = 1'b1;
    bus.excode  = EX_ADES;
    bus.pc      = 32'h0000_0800;
    bus.badvaddr = 32'h0000_0777;
    step();
    reset = 1'b0;
    bus   = '0;
    rd(CR_COUNT, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL midreset_count got=%h exp=0", d); end
    rd(CR_STATUS, d);
    checks++; if (d !== 32'h0040_0000) begin failures++; $display("FAIL midreset_status got=%h exp=00400000", d); end
    rd(CR_BADVADDR, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL midreset_badvaddr got=%h exp=0", d); end
    checks++; if (cp0_epc !== 32'h0) begin failures++; $display("FAIL midreset_epc got=%h exp=0", cp0_epc); end
    checks++; if (cp0_status_exl !== 1'b0) begin failures++; $display("FAIL midreset_exl got=%b exp=0", cp0_status_exl); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    bus = '0;
    ext_int_in = '0;
    test_reset();
    test_exception();
    test_eret_priority();
    test_timer();
    test_sw_hw_int();
    test_count_wrap_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
